// File: rtl/cafe_pkg.sv
// Shared constants for the drink dispenser: ingredient slots, FSM states
// and the factory recipe table.
package cafe_pkg;

    localparam int ING_SUGAR     = 0;
    localparam int ING_CHOCOLATE = 1;
    localparam int ING_MILK      = 2;
    localparam int ING_COFFEE    = 3;
    localparam int ING_WATER     = 4;

    localparam int N_ING_DEF    = 5;
    localparam int N_RECIPE_DEF = 4;
    localparam int DUR_W_DEF    = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        POUR,
        DONE
    } state_t;

    typedef logic [N_ING_DEF-1:0][DUR_W_DEF-1:0] recipe_row_t;

    function automatic recipe_row_t mk_row(input int unsigned water, input int unsigned coffee,
                                           input int unsigned milk, input int unsigned chocolate,
                                           input int unsigned sugar);
        recipe_row_t row;
        row                = '0;
        row[ING_WATER]     = DUR_W_DEF'(water);
        row[ING_COFFEE]    = DUR_W_DEF'(coffee);
        row[ING_MILK]      = DUR_W_DEF'(milk);
        row[ING_CHOCOLATE] = DUR_W_DEF'(chocolate);
        row[ING_SUGAR]     = DUR_W_DEF'(sugar);
        return row;
    endfunction

    // Rows ordered MSB..LSB: mocca, cappuccino, latte, espresso.
    localparam logic [N_RECIPE_DEF-1:0][N_ING_DEF-1:0][DUR_W_DEF-1:0] DEFAULT_RECIPE = {
        mk_row(1, 1, 1, 2, 1),
        mk_row(2, 1, 2, 0, 1),
        mk_row(2, 2, 1, 0, 1),
        mk_row(2, 3, 0, 0, 1)
    };

endpackage

// File: rtl/sec_timer.sv
// Pour timer: a tick prescaler dividing the clock into seconds, feeding a
// second down-counter; expired flags the very last tick of the last second.
module sec_timer #(
    parameter int DUR_W         = 4,
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enable,
    input  logic [DUR_W-1:0] dur,
    output logic             expired
);

    localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_PER_SEC - 1);

    logic [TW-1:0]    tick;
    logic [DUR_W-1:0] secs;
    logic             tick_wrap;

    assign tick_wrap = (tick == '0);
    assign expired   = enable && tick_wrap && (secs == DUR_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tick <= '0;
            secs <= '0;
        end else if (load) begin
            tick <= TICK_MAX;
            secs <= dur;
        end else if (enable) begin
            if (tick_wrap) begin
                tick <= TICK_MAX;
                if (secs != '0)
                    secs <= secs - DUR_W'(1);
            end else begin
                tick <= tick - TW'(1);
            end
        end
    end

endmodule

// File: rtl/dispense_sequencer.sv
// Drink dispenser sequencer: latches a recipe row on start and opens each
// nonzero-duration valve in turn, from water down to sugar.
module dispense_sequencer
    import cafe_pkg::*;
#(
    parameter int N_ING         = 5,
    parameter int N_RECIPE      = 4,
    parameter int DUR_W         = 4,
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter logic [N_RECIPE-1:0][N_ING-1:0][DUR_W-1:0] RECIPE = cafe_pkg::DEFAULT_RECIPE
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                start,
    input  logic [N_RECIPE-1:0] selection,
    input  logic                abort,
    output logic [N_ING-1:0]    status,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic                error
);

    localparam int IW = (N_ING > 1) ? $clog2(N_ING) : 1;
    localparam int RW = $clog2(N_ING + 1);

    state_t                      state, state_n;
    logic [N_ING-1:0][DUR_W-1:0] row_q, sel_row;
    logic [RW-1:0]               remaining;
    logic [IW-1:0]               cur_idx, hit_idx;
    logic                        hit_found;
    logic                        start_ok, start_bad, abort_take;
    logic                        tmr_load, tmr_en, tmr_expired;
    logic                        aborted_q, error_q;

    always_comb begin
        sel_row = '0;
        for (int unsigned r = 0; r < N_RECIPE; r++)
            if (selection[r])
                sel_row = sel_row | RECIPE[r];
    end

    // remaining holds index+1 so that stepping past ingredient 0 lands on 0
    // instead of wrapping; the search only looks at slots below it.
    always_comb begin
        hit_found = 1'b0;
        hit_idx   = '0;
        for (int unsigned i = 0; i < N_ING; i++) begin
            if ((RW'(i) < remaining) && (row_q[i] != '0)) begin
                hit_found = 1'b1;
                hit_idx   = IW'(i);
            end
        end
    end

    assign start_ok   = (state == IDLE) && start && $onehot(selection);
    assign start_bad  = (state == IDLE) && start && !$onehot(selection);
    assign abort_take = abort && ((state == LOAD) || (state == POUR));

    always_comb begin
        state_n  = state;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        case (state)
            IDLE: if (start_ok) state_n = LOAD;
            LOAD: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (hit_found) begin
                    tmr_load = 1'b1;
                    state_n  = POUR;
                end else begin
                    state_n = DONE;
                end
            end
            POUR: begin
                tmr_en = 1'b1;
                if (abort)
                    state_n = IDLE;
                else if (tmr_expired)
                    state_n = LOAD;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            row_q     <= '0;
            remaining <= '0;
            cur_idx   <= '0;
            aborted_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state     <= state_n;
            aborted_q <= abort_take;
            error_q   <= start_bad;
            if (start_ok) begin
                row_q     <= sel_row;
                remaining <= RW'(N_ING);
            end
            if (tmr_load)
                cur_idx <= hit_idx;
            if ((state == POUR) && tmr_expired && !abort)
                remaining <= RW'(cur_idx);
        end
    end

    sec_timer #(
        .DUR_W         (DUR_W),
        .TICKS_PER_SEC (TICKS_PER_SEC)
    ) u_timer (
        .clk     (Clock),
        .rst     (Reset),
        .load    (tmr_load),
        .enable  (tmr_en),
        .dur     (row_q[hit_idx]),
        .expired (tmr_expired)
    );

    always_comb begin
        status = '0;
        if (state == POUR)
            status = N_ING'(1) << cur_idx;
    end

    assign busy    = (state == LOAD) || (state == POUR);
    assign done    = (state == DONE);
    assign aborted = aborted_q;
    assign error   = error_q;

endmodule

// File: tb/tb_dispense_sequencer.sv
// Cycle-by-cycle vector bench for dispense_sequencer at 4 ticks per second,
// plus a second instance with an empty latte row.
module tb_dispense_sequencer;
    import cafe_pkg::*;

    localparam logic [4:0] W  = 5'b10000;
    localparam logic [4:0] C  = 5'b01000;
    localparam logic [4:0] M  = 5'b00100;
    localparam logic [4:0] H  = 5'b00010;
    localparam logic [4:0] S  = 5'b00001;
    localparam logic [4:0] Z  = 5'b00000;

    localparam logic [3:0][4:0][3:0] ZERO_LATTE =
        {DEFAULT_RECIPE[3], DEFAULT_RECIPE[2], 20'd0, DEFAULT_RECIPE[0]};

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] selection = '0;
    logic       abort = 1'b0;
    logic [4:0] status;
    logic       busy, done, aborted, error;

    logic       start2 = 1'b0;
    logic [3:0] sel2 = '0;
    logic [4:0] status2;
    logic       busy2, done2, aborted2, error2;

    int tests  = 0;
    int failed = 0;

    always #5 Clock = ~Clock;

    dispense_sequencer #(.TICKS_PER_SEC(4)) dut (
        .Clock(Clock), .Reset(Reset), .start(start), .selection(selection), .abort(abort),
        .status(status), .busy(busy), .done(done), .aborted(aborted), .error(error)
    );

    dispense_sequencer #(.TICKS_PER_SEC(4), .RECIPE(ZERO_LATTE)) dut2 (
        .Clock(Clock), .Reset(Reset), .start(start2), .selection(sel2), .abort(1'b0),
        .status(status2), .busy(busy2), .done(done2), .aborted(aborted2), .error(error2)
    );

    typedef struct {
        logic       rst;
        logic       start;
        logic [3:0] sel;
        logic       abort;
        logic [4:0] status;
        logic       busy;
        logic       done;
        logic       aborted;
        logic       error;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int n, input logic rst, input logic st, input logic [3:0] sel,
                       input logic ab, input logic [4:0] stat, input logic bz, input logic dn,
                       input logic abd, input logic er);
        vec_t v;
        v = '{rst, st, sel, ab, stat, bz, dn, abd, er};
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    task automatic pour(input int n, input logic [4:0] stat);
        add(n, 0, 0, 4'b0000, 0, stat, 1, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        add(n, 0, 0, 4'b0000, 0, Z, 0, 0, 0, 0);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    initial begin
        // Espresso with starts ignored in POUR/LOAD/DONE and aborts ignored in DONE/IDLE.
        add(1, 0, 1, 4'b0001, 0, Z, 0, 0, 0, 0);
        pour(1, Z);
        pour(3, W); add(1, 0, 1, 4'b0001, 0, W, 1, 0, 0, 0); pour(4, W);
        pour(1, Z);
        pour(1, C); add(1, 0, 1, 4'b0011, 0, C, 1, 0, 0, 0); pour(10, C);
        add(1, 0, 1, 4'b1000, 0, Z, 1, 0, 0, 0);
        pour(4, S);
        pour(1, Z);
        add(1, 0, 1, 4'b0110, 1, Z, 0, 1, 0, 0);
        add(1, 0, 0, 4'b0000, 1, Z, 0, 0, 0, 0);
        idle(1);
        // Mocca: every valve, chocolate for two seconds.
        add(1, 0, 1, 4'b1000, 0, Z, 0, 0, 0, 0);
        pour(1, Z); pour(4, W);
        pour(1, Z); pour(4, C);
        pour(1, Z); pour(4, M);
        pour(1, Z); pour(8, H);
        pour(1, Z); pour(4, S);
        pour(1, Z);
        add(1, 0, 0, 4'b0000, 0, Z, 0, 1, 0, 0);
        idle(1);
        // Bad selections.
        add(1, 0, 1, 4'b0110, 0, Z, 0, 0, 0, 0);
        add(1, 0, 1, 4'b0000, 0, Z, 0, 0, 0, 1);
        add(1, 0, 0, 4'b0000, 0, Z, 0, 0, 0, 1);
        idle(1);
        // Latte aborted during coffee, restarted, aborted during water.
        add(1, 0, 1, 4'b0010, 0, Z, 0, 0, 0, 0);
        pour(1, Z); pour(8, W);
        pour(1, Z); pour(2, C);
        add(1, 0, 0, 4'b0000, 1, C, 1, 0, 0, 0);
        add(1, 0, 0, 4'b0000, 0, Z, 0, 0, 1, 0);
        add(1, 0, 1, 4'b0010, 0, Z, 0, 0, 0, 0);
        pour(1, Z);
        add(1, 0, 0, 4'b0000, 1, W, 1, 0, 0, 0);
        add(1, 0, 0, 4'b0000, 0, Z, 0, 0, 1, 0);
        idle(1);
        // Cappuccino reset mid-milk (with abort and start also high), then full run.
        add(1, 0, 1, 4'b0100, 0, Z, 0, 0, 0, 0);
        pour(1, Z); pour(8, W);
        pour(1, Z); pour(4, C);
        pour(1, Z); pour(2, M);
        add(1, 1, 1, 4'b0001, 1, M, 1, 0, 0, 0);
        idle(1);
        add(1, 0, 1, 4'b0100, 0, Z, 0, 0, 0, 0);
        pour(1, Z); pour(8, W);
        pour(1, Z); pour(4, C);
        pour(1, Z); pour(8, M);
        pour(1, Z); pour(4, S);
        pour(1, Z);
        add(1, 0, 0, 4'b0000, 0, Z, 0, 1, 0, 0);
        idle(1);
        // Espresso aborted on the final sugar tick.
        add(1, 0, 1, 4'b0001, 0, Z, 0, 0, 0, 0);
        pour(1, Z); pour(8, W);
        pour(1, Z); pour(12, C);
        pour(1, Z); pour(3, S);
        add(1, 0, 0, 4'b0000, 1, S, 1, 0, 0, 0);
        add(1, 0, 0, 4'b0000, 0, Z, 0, 0, 1, 0);
        idle(2);

        repeat (2) @(posedge Clock);
        @(negedge Clock);
        check("reset_outputs", {27'd0, status, busy, done, aborted, error}, 32'd0);
        check("reset_outputs2", {27'd0, status2, busy2, done2, aborted2, error2}, 32'd0);
        Reset = 1'b0;

        foreach (tbl[j]) begin
            @(negedge Clock);
            tests++;
            if ({status, busy, done, aborted, error} !==
                {tbl[j].status, tbl[j].busy, tbl[j].done, tbl[j].aborted, tbl[j].error}) begin
                failed++;
                $display("FAIL vec%0d: got status=%b busy=%b done=%b aborted=%b error=%b, want status=%b busy=%b done=%b aborted=%b error=%b",
                         j, status, busy, done, aborted, error,
                         tbl[j].status, tbl[j].busy, tbl[j].done, tbl[j].aborted, tbl[j].error);
            end
            Reset     = tbl[j].rst;
            start     = tbl[j].start;
            selection = tbl[j].sel;
            abort     = tbl[j].abort;
        end
        Reset = 1'b0; start = 1'b0; selection = '0; abort = 1'b0;

        // Empty recipe row: LOAD at k+1, done at k+2.
        @(negedge Clock);
        start2 = 1'b1; sel2 = 4'b0010;
        @(negedge Clock);
        start2 = 1'b0; sel2 = '0;
        check("empty_k1", {29'd0, busy2, done2, |status2}, {29'd0, 3'b100});
        @(negedge Clock);
        check("empty_k2", {29'd0, busy2, done2, |status2}, {29'd0, 3'b010});
        @(negedge Clock);
        check("empty_k3", {29'd0, busy2, done2, |status2}, 32'd0);

        // Espresso on the second instance: done must appear exactly 29 cycles after start.
        begin
            int n;
            start2 = 1'b1; sel2 = 4'b0001;
            n = 0;
            while (n < 40) begin
                @(negedge Clock);
                start2 = 1'b0; sel2 = '0;
                n++;
                if (done2) break;
            end
            check("espresso_done_latency", n, 29);
            @(negedge Clock);
            check("espresso_done_width", {31'd0, done2}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
